// File: rtl/serial_shifter32_pkg.sv
// Shared encodings and default widths for the multicycle serial shifter.
// Imported by the top and by the one-bit shift stage.
package serial_shifter32_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int SHW_DEF   = 5;

   localparam logic [1:0] OP_SLL  = 2'd0;
   localparam logic [1:0] OP_SRL  = 2'd1;
   localparam logic [1:0] OP_SRA  = 2'd2;
   localparam logic [1:0] OP_ROTL = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_shifter32_shift1.sv
// Combinational single-bit shift stage selected by op.
// The top applies it once per clock to walk the operand to its final position.
module shift1_unit
   import serial_shifter32_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] shifted
);

   always_comb begin
      shifted = data;
      case (op)
         OP_SLL:  shifted = {data[WIDTH-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, data[WIDTH-1:1]};
         OP_SRA:  shifted = {data[WIDTH-1], data[WIDTH-1:1]};
         OP_ROTL: shifted = {data[WIDTH-2:0], data[WIDTH-1]};
         default: shifted = data;
      endcase
   end

endmodule

// File: rtl/serial_shifter32.sv
// Multicycle shift unit: one bit per clock with a start/busy/done handshake.
// The shift operand arrives zero-extended; only its low SHW bits are used as the count.
module serial_shifter32
   import serial_shifter32_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SHW   = SHW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] shamt_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             shamt_range_err
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] shifted;
   logic [SHW-1:0]   count;
   logic [1:0]       op_q;
   logic             accept;

   // A new request is taken whenever no shift is in flight, including the done cycle.
   assign accept = start && (state != S_SHIFT);

   shift1_unit #(.WIDTH(WIDTH)) u_shift1 (
      .op      (op_q),
      .data    (work),
      .shifted (shifted)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_SHIFT;
         S_SHIFT: if (count == '0) state_next = S_DONE;
         S_DONE:  state_next = start ? S_SHIFT : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // busy and done come from the next state so both are true flops, not decodes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         work            <= '0;
         count           <= '0;
         op_q            <= OP_SLL;
         shamt_range_err <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         busy <= (state_next == S_SHIFT);
         done <= (state_next == S_DONE);
         if (accept) begin
            work            <= data_in;
            count           <= shamt_in[SHW-1:0];
            op_q            <= op;
            shamt_range_err <= |shamt_in[WIDTH-1:SHW];
         end else if ((state == S_SHIFT) && (count != '0)) begin
            work  <= shifted;
            count <= count - 1'b1;
         end
      end
   end

   assign result = work;

endmodule

// File: tb/tb_serial_shifter32.sv
// Directed self-checking bench for serial_shifter32 with hand-computed expectations.
// Outputs are sampled 1 time unit after the rising edge.
module tb_serial_shifter32;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] data_in;
   logic [31:0] shamt_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        shamt_range_err;

   int checks;
   int failures;
   int lat;
   logic done_seen;

   serial_shifter32 dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .op              (op),
      .data_in         (data_in),
      .shamt_in        (shamt_in),
      .busy            (busy),
      .done            (done),
      .result          (result),
      .shamt_range_err (shamt_range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive a request before an edge; it is accepted on that edge and start drops 1 unit later.
   task automatic applyStimulus(input logic [31:0] d, input logic [31:0] s, input logic [1:0] o);
      @(negedge clk);
      data_in  = d;
      shamt_in = s;
      op       = o;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input string tag, output int cycles);
      cycles = 0;
      while (cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
         if (done) break;
      end
      if (!done) checkOutput({tag, "_timeout"}, {31'd0, done}, 32'd1);
   endtask

   task automatic runOp(input string tag, input logic [31:0] d, input logic [31:0] s, input logic [1:0] o,
                        input logic [31:0] exp_result, input logic exp_err, input int exp_lat);
      applyStimulus(d, s, o);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      waitDone(tag, lat);
      checkOutput({tag, "_latency"}, lat, exp_lat);
      checkOutput({tag, "_result"}, result, exp_result);
      checkOutput({tag, "_err"}, {31'd0, shamt_range_err}, {31'd0, exp_err});
      checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_result_hold"}, result, exp_result);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      start    = 1'b0;
      op       = 2'd0;
      data_in  = '0;
      shamt_in = '0;

      #3;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_result", result, 32'd0);
      checkOutput("reset_err", {31'd0, shamt_range_err}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      runOp("sll4", 32'h0000_0001, 32'd4, 2'd0, 32'h0000_0010, 1'b0, 5);
      runOp("sra31", 32'h8000_0000, 32'd31, 2'd2, 32'hFFFF_FFFF, 1'b0, 32);
      runOp("srl31", 32'h8000_0000, 32'd31, 2'd1, 32'h0000_0001, 1'b0, 32);
      runOp("sra_pos", 32'h4000_0000, 32'd4, 2'd2, 32'h0400_0000, 1'b0, 5);
      runOp("rotl0", 32'hDEAD_BEEF, 32'd0, 2'd3, 32'hDEAD_BEEF, 1'b0, 1);
      runOp("rotl8", 32'hDEAD_BEEF, 32'd8, 2'd3, 32'hADBE_EFDE, 1'b0, 9);
      runOp("rotl_wrap", 32'h8000_0001, 32'd1, 2'd3, 32'h0000_0003, 1'b0, 2);
      runOp("range_0x100", 32'h1234_5678, 32'h0000_0100, 2'd2, 32'h1234_5678, 1'b1, 1);
      runOp("range_0x21", 32'h0000_0003, 32'h0000_0021, 2'd0, 32'h0000_0006, 1'b1, 2);

      // Abort mid-shift: outputs clear asynchronously and no done ever follows.
      applyStimulus(32'hFFFF_0000, 32'd20, 2'd0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_result", result, 32'd0);
      checkOutput("abort_err", {31'd0, shamt_range_err}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      done_seen = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) done_seen = 1'b1;
      end
      checkOutput("abort_no_done", {31'd0, done_seen}, 32'd0);
      runOp("after_abort", 32'h0000_00F0, 32'd4, 2'd1, 32'h0000_000F, 1'b0, 5);

      // Start held through busy with changing inputs is ignored; start in the done cycle is taken.
      @(negedge clk);
      data_in  = 32'h0000_0001;
      shamt_in = 32'd3;
      op       = 2'd0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      data_in  = 32'hFFFF_FFFF;
      shamt_in = 32'h0000_0100;
      op       = 2'd3;
      checkOutput("hs_busy", {31'd0, busy}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("hs_done", {31'd0, done}, 32'd1);
      checkOutput("hs_result", result, 32'h0000_0008);
      checkOutput("hs_err", {31'd0, shamt_range_err}, 32'd0);
      data_in  = 32'h0000_00F0;
      shamt_in = 32'd4;
      op       = 2'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("hs_b2b_busy", {31'd0, busy}, 32'd1);
      checkOutput("hs_b2b_done_low", {31'd0, done}, 32'd0);
      waitDone("hs_b2b", lat);
      checkOutput("hs_b2b_latency", lat, 32'd5);
      checkOutput("hs_b2b_result", result, 32'h0000_000F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
